// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the universal shift register:
//   - 3-bit operation codes MODE_HOLD .. MODE_ROR (code 7 is reserved)
//   - FSM state encoding for the burst engine
//   - is_shift_mode(): true for modes that move bits and may start a burst
// Configuration macro: UNIV_SHIFT_REG_ROTATE_EN
//   When it is defined, ROL/ROR count as shift modes.
//   When it is not defined, only SHL/SHR/ASR count as shift modes.
// ---------------------------------------------------------------------------
package shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ASR  = 3'd4;
    localparam logic [2:0] MODE_ROL  = 3'd5;
    localparam logic [2:0] MODE_ROR  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_shift_mode(input logic [2:0] m);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        return (m >= MODE_SHL) && (m <= MODE_ROR);
`else
        return (m >= MODE_SHL) && (m <= MODE_ASR);
`endif
    endfunction

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Purely combinational next-state function of the shift register.
// It computes the next register value and the bits shifted out for one
// shift or rotate. LOAD is handled by the caller, because pdata is not an
// input here.
// Configuration macro: UNIV_SHIFT_REG_ROTATE_EN
//   When it is not defined, ROL/ROR are not built and behave as HOLD.
// Ports:
//   i_q     in  WIDTH  current register value
//   i_sin   in  STEP   serial fill bits
//   i_op    in  3      operation code (shift_pkg MODE_*)
//   o_q     out WIDTH  next register value (equals i_q when o_shift=0)
//   o_sout  out STEP   bits moved out (meaningful only when o_shift=1)
//   o_shift out 1      op is a shift/rotate that updates q and sout
// ---------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [STEP-1:0]  i_sin,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_q,
    output logic [STEP-1:0]  o_sout,
    output logic             o_shift
);

    always_comb begin
        o_q     = i_q;
        o_sout  = '0;
        o_shift = 1'b0;
        case (i_op)
            MODE_SHL: begin
                o_q     = {i_q[WIDTH-STEP-1:0], i_sin};
                o_sout  = i_q[WIDTH-1 -: STEP];
                o_shift = 1'b1;
            end
            MODE_SHR: begin
                o_q     = {i_sin, i_q[WIDTH-1:STEP]};
                o_sout  = i_q[STEP-1:0];
                o_shift = 1'b1;
            end
            MODE_ASR: begin
                o_q     = {{STEP{i_q[WIDTH-1]}}, i_q[WIDTH-1:STEP]};
                o_sout  = i_q[STEP-1:0];
                o_shift = 1'b1;
            end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            MODE_ROL: begin
                o_q     = {i_q[WIDTH-STEP-1:0], i_q[WIDTH-1 -: STEP]};
                o_sout  = i_q[WIDTH-1 -: STEP];
                o_shift = 1'b1;
            end
            MODE_ROR: begin
                o_q     = {i_q[STEP-1:0], i_q[WIDTH-1:STEP]};
                o_sout  = i_q[STEP-1:0];
                o_shift = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
// Universal shift register with parallel load, STEP-bit logical,
// arithmetic and rotate shifts. It includes a burst engine that performs
// `len` shifts of a latched mode and then pulses `done` for one cycle.
// Configuration macro: UNIV_SHIFT_REG_ROTATE_EN
//   This macro enables ROL/ROR, both as direct ops and as burst modes.
// Ports:
//   clk    in  1      rising-edge clock
//   reset  in  1      synchronous active-high reset, highest priority
//   ena    in  1      global enable. When low, all state holds, except
//                     that DONE always returns to IDLE.
//   mode   in  3      operation select (shift_pkg MODE_*)
//   sin    in  STEP   serial fill bits
//   pdata  in  WIDTH  parallel load data
//   start  in  1      burst request (only taken in IDLE with a shift mode)
//   len    in  LEN_W  burst shift count
//   q      out WIDTH  register contents
//   sout   out STEP   bits shifted out by the latest shift/rotate
//   busy   out 1      high while the burst engine is in RUN
//   done   out 1      one-cycle pulse after the last burst shift
// ---------------------------------------------------------------------------
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [2:0]       mode,
    input  logic [STEP-1:0]  sin,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] q,
    output logic [STEP-1:0]  sout,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 2 || STEP < 1 || STEP >= WIDTH) begin : g_bad_params
        $error("univ_shift_reg: need WIDTH >= 2 and 1 <= STEP < WIDTH");
    end

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [2:0]       r_run_mode;
    logic [WIDTH-1:0] r_q;
    logic [STEP-1:0]  r_sout;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_q_nxt;
    logic [STEP-1:0]  w_sout_nxt;
    logic             w_shift;

    // The single datapath is shared. RUN steers it with the latched burst
    // mode, and every other state uses the live mode input.
    assign w_op = (r_state == ST_RUN) ? r_run_mode : mode;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .i_q     (r_q),
        .i_sin   (sin),
        .i_op    (w_op),
        .o_q     (w_q_nxt),
        .o_sout  (w_sout_nxt),
        .o_shift (w_shift)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_run_mode <= MODE_HOLD;
            r_q        <= '0;
            r_sout     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (r_state == ST_DONE) begin
            // DONE always lasts one cycle, even when ena is low.
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else if (ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (start && is_shift_mode(mode)) begin
                        // A burst request replaces the direct shift on this
                        // cycle. q does not move until the first RUN edge.
                        r_run_mode <= mode;
                        r_cnt      <= len;
                        if (len != '0) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (mode == MODE_LOAD) begin
                        r_q <= pdata;
                    end else if (w_shift) begin
                        r_q    <= w_q_nxt;
                        r_sout <= w_sout_nxt;
                    end
                end
                ST_RUN: begin
                    r_q    <= w_q_nxt;
                    r_sout <= w_sout_nxt;
                    r_cnt  <= r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign sout = r_sout;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
// Bench for univ_shift_reg with WIDTH=8. Two instances share the stimulus.
// u_dut1 uses STEP=1 and carries the burst tests. u_dut2 uses STEP=2 and
// carries the multi-bit step tests. Each driven cycle pushes its expected
// outputs, stamped with the cycle they belong to, onto a scoreboard. A
// negedge process pops them and compares them with the selected instance.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic [2:0] mode;
    logic [0:0] sin1;
    logic [1:0] sin2;
    logic [7:0] pdata;
    logic       start;
    logic [7:0] len;

    logic [7:0] q1, q2;
    logic [0:0] sout1;
    logic [1:0] sout2;
    logic       busy1, busy2, done1, done2;

    univ_shift_reg #(.WIDTH(8), .STEP(1), .LEN_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .ena(ena), .mode(mode), .sin(sin1),
        .pdata(pdata), .start(start), .len(len),
        .q(q1), .sout(sout1), .busy(busy1), .done(done1)
    );

    univ_shift_reg #(.WIDTH(8), .STEP(2), .LEN_W(8)) u_dut2 (
        .clk(clk), .reset(reset), .ena(ena), .mode(mode), .sin(sin2),
        .pdata(pdata), .start(start), .len(len),
        .q(q2), .sout(sout2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        string      tag;
        bit         sel;    // 0: u_dut1 (STEP=1), 1: u_dut2 (STEP=2)
        logic [7:0] q;
        int         sout;   // -1: do not compare sout
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.sel) begin
                check({e.tag, "_q"},    32'(q2),    32'(e.q));
                if (e.sout >= 0) check({e.tag, "_sout"}, 32'(sout2), 32'(e.sout));
                check({e.tag, "_busy"}, 32'(busy2), 32'(e.busy));
                check({e.tag, "_done"}, 32'(done2), 32'(e.done));
            end else begin
                check({e.tag, "_q"},    32'(q1),    32'(e.q));
                if (e.sout >= 0) check({e.tag, "_sout"}, 32'(sout1), 32'(e.sout));
                check({e.tag, "_busy"}, 32'(busy1), 32'(e.busy));
                check({e.tag, "_done"}, 32'(done1), 32'(e.done));
            end
        end
    end

    // Drive one cycle of stimulus and push the outputs expected after its edge.
    task automatic drv(input string tag, input bit sel,
                       input logic e, input logic [2:0] m, input logic [1:0] s,
                       input logic [7:0] pd, input logic st, input logic [7:0] ln,
                       input logic rs,
                       input logic [7:0] eq, input int es, input logic eb, input logic ed);
        exp_t x;
        reset = rs; ena = e; mode = m; sin2 = s; sin1 = s[0];
        pdata = pd; start = st; len = ln;
        x.due = cyc + 1; x.tag = tag; x.sel = sel;
        x.q = eq; x.sout = es; x.busy = eb; x.done = ed;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and load
        drv("rst1",    0, 0, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 1, 8'h00, 0, 0, 0);
        drv("rst2",    1, 0, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 1, 8'h00, 0, 0, 0);
        drv("load_a5", 0, 1, MODE_LOAD, 2'b00, 8'hA5, 0, 8'd0, 0, 8'hA5, 0, 0, 0);

        // Two-bit step direct ops on u_dut2
        drv("load_b4", 1, 1, MODE_LOAD, 2'b00, 8'hB4, 0, 8'd0, 0, 8'hB4, 0, 0, 0);
        drv("shl2",    1, 1, MODE_SHL,  2'b11, 8'h00, 0, 8'd0, 0, 8'hD3, 2, 0, 0);
        drv("reload",  1, 1, MODE_LOAD, 2'b00, 8'hB4, 0, 8'd0, 0, 8'hB4, 2, 0, 0);
        drv("asr2",    1, 1, MODE_ASR,  2'b01, 8'h00, 0, 8'd0, 0, 8'hED, 0, 0, 0);
        drv("shr2",    1, 1, MODE_SHR,  2'b01, 8'h00, 0, 8'd0, 0, 8'h7B, 1, 0, 0);
        drv("hold",    1, 1, MODE_HOLD, 2'b11, 8'h00, 0, 8'd0, 0, 8'h7B, 1, 0, 0);
        drv("rsvd",    1, 1, 3'd7,      2'b11, 8'h00, 0, 8'd0, 0, 8'h7B, 1, 0, 0);
        drv("ena_low", 1, 0, MODE_LOAD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h7B, 1, 0, 0);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        drv("ror2",    1, 1, MODE_ROR,  2'b00, 8'h00, 0, 8'd0, 0, 8'hDE, 3, 0, 0);
`else
        drv("ror2",    1, 1, MODE_ROR,  2'b00, 8'h00, 0, 8'd0, 0, 8'h7B, 1, 0, 0);
`endif

        // Rotate burst on u_dut1
        drv("load_81", 0, 1, MODE_LOAD, 2'b00, 8'h81, 0, 8'd0, 0, 8'h81, -1, 0, 0);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        drv("ror_e0",  0, 1, MODE_ROR,  2'b00, 8'h00, 1, 8'd3, 0, 8'h81, -1, 1, 0);
        drv("ror_e1",  0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'hC0, 1, 1, 0);
        drv("ror_e2",  0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h60, 0, 1, 0);
        drv("ror_e3",  0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h30, 0, 0, 1);
        drv("ror_e4",  0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h30, 0, 0, 0);
`else
        drv("ror_e0",  0, 1, MODE_ROR,  2'b00, 8'h00, 1, 8'd3, 0, 8'h81, -1, 0, 0);
        for (int i = 0; i < 4; i++)
            drv("ror_off", 0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h81, -1, 0, 0);
`endif

        // Stalled SHL burst, with a start during RUN that must be ignored
        drv("load_8f", 0, 1, MODE_LOAD, 2'b00, 8'h8F, 0, 8'd0, 0, 8'h8F, -1, 0, 0);
        drv("st_e0",   0, 1, MODE_SHL,  2'b00, 8'h00, 1, 8'd4, 0, 8'h8F, -1, 1, 0);
        drv("st_e1",   0, 1, MODE_LOAD, 2'b00, 8'hFF, 1, 8'd9, 0, 8'h1E, 1, 1, 0);
        drv("st_s1",   0, 0, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h1E, 1, 1, 0);
        drv("st_s2",   0, 0, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h1E, 1, 1, 0);
        drv("st_e2",   0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h3C, 0, 1, 0);
        drv("st_e3",   0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h78, 0, 1, 0);
        drv("st_e4",   0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'hF0, 0, 0, 1);
        drv("st_idle", 0, 0, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'hF0, 0, 0, 0);
        drv("load_55", 0, 1, MODE_LOAD, 2'b00, 8'h55, 0, 8'd0, 0, 8'h55, 0, 0, 0);

        // len = 0 burst: immediate done, no busy, no shift
        drv("len0_e0", 0, 1, MODE_SHR,  2'b11, 8'h00, 1, 8'd0, 0, 8'h55, 0, 0, 1);
        drv("len0_e1", 0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h55, 0, 0, 0);

        // start with LOAD: load only
        drv("stld_e0", 0, 1, MODE_LOAD, 2'b00, 8'h3C, 1, 8'd5, 0, 8'h3C, 0, 0, 0);
        drv("stld_e1", 0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h3C, 0, 0, 0);

        // Abort a len=5 SHR burst with reset in its second RUN cycle
        drv("ab_e0",   0, 1, MODE_SHR,  2'b00, 8'h00, 1, 8'd5, 0, 8'h3C, 0, 1, 0);
        drv("ab_e1",   0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h1E, 0, 1, 0);
        drv("ab_rst",  0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 1, 8'h00, 0, 0, 0);
        drv("ab_post", 0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h00, 0, 0, 0);
        drv("ab_post2",0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h00, 0, 0, 0);

        // The next burst after the abort runs normally
        drv("nb_load", 0, 1, MODE_LOAD, 2'b00, 8'h01, 0, 8'd0, 0, 8'h01, 0, 0, 0);
        drv("nb_e0",   0, 1, MODE_SHL,  2'b01, 8'h00, 1, 8'd2, 0, 8'h01, 0, 1, 0);
        drv("nb_e1",   0, 1, MODE_HOLD, 2'b01, 8'h00, 0, 8'd0, 0, 8'h03, 0, 1, 0);
        drv("nb_e2",   0, 1, MODE_HOLD, 2'b01, 8'h00, 0, 8'd0, 0, 8'h07, 0, 0, 1);
        drv("nb_e3",   0, 1, MODE_HOLD, 2'b00, 8'h00, 0, 8'd0, 0, 8'h07, 0, 0, 0);

        // Let the scoreboard drain, with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
